// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with a centred 2x-scaled 256x240 NES window.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int NES_X_OFS = 64
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       nes_active,
  output logic [7:0] nes_x,
  output logic [7:0] nes_y,
  output logic       line_start,
  output logic       frame_start
);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] NX0 = 10'(NES_X_OFS);
  localparam logic [9:0] NX1 = 10'(NES_X_OFS + 512);
  logic [9:0] hc, vc, nx_sub;
  logic       h_end, v_act, hs_d, vs_d, bl_d, na_d, ls_d, fs_d;
  logic [7:0] nx_d, ny_d;
  assign h_end = hc == HL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= h_end ? '0 : hc + 10'd1;
      if (h_end) vc <= (vc == VL) ? '0 : vc + 10'd1;
    end
  end
  // Decode the current counter position; the registers below present it one cycle later.
  always_comb begin
    v_act  = vc < VA;
    hs_d   = (hc >= HS0 && hc < HS1) ? HSYNC_POL : ~HSYNC_POL;
    vs_d   = (vc >= VS0 && vc < VS1) ? VSYNC_POL : ~VSYNC_POL;
    bl_d   = hc >= HA || !v_act;
    na_d   = hc >= NX0 && hc < NX1 && v_act;
    nx_sub = hc - NX0;
    nx_d   = na_d ? nx_sub[8:1] : 8'd0;
    ny_d   = na_d ? vc[8:1] : 8'd0;
    ls_d   = hc == '0 && v_act;
    fs_d   = hc == '0 && vc == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      nes_active  <= 1'b0;
      nes_x       <= '0;
      nes_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_d;
      vsync       <= vs_d;
      blank       <= bl_d;
      h_cnt       <= hc;
      v_cnt       <= vc;
      nes_active  <= na_d;
      nes_x       <= nx_d;
      nes_y       <= ny_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end
endmodule
